// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the RISC-V run controller.
package riscv_run_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } run_state_e;

  typedef enum logic [1:0] {
    NONE,
    TOHOST,
    STALL,
    TIMEOUT
  } halt_cause_e;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FF0;

endpackage

// File: rtl/riscv_pc_stall_detector.sv
// Flags a PC self-loop: pc unchanged for STALL_LIMIT consecutive enabled cycles.
// The stall output is combinational so the controller can register it with the
// other halt causes on the same edge.
module riscv_pc_stall_detector #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            a_rstn,
  input  logic            clear,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  output logic            stall
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;
  logic [CW-1:0]   eq_cnt;
  logic            pc_same;

  // No comparison until one pc has been captured since the last clear.
  assign pc_same = en && prev_valid && (pc == prev_pc);
  assign stall   = pc_same && (eq_cnt == CW'(STALL_LIMIT - 1));

  // Track previous pc and the run length of unchanged-pc cycles.
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      eq_cnt     <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      eq_cnt     <= '0;
    end else if (en) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      if (pc_same) begin
        if (eq_cnt != CW'(STALL_LIMIT)) eq_cnt <= eq_cnt + 1'b1;
      end else begin
        eq_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: sequences core reset,
// counts run cycles and detects end-of-test (tohost store, pc loop, timeout).
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int unsigned     RST_CYCLES     = 2,
  parameter int unsigned     TIMEOUT_CYCLES = 50,
  parameter int unsigned     STALL_LIMIT    = 4,
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned     CNT_W          = 32,
  parameter bit              AUTO_START     = 1'b1
) (
  input  logic             clk,
  input  logic             a_rstn,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rstn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             stalled,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned      RST_W        = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST     = RST_W'(RST_CYCLES - 1);
  // cycle_count still holds the previous total during the halting cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  run_state_e       state, state_nxt;
  halt_cause_e      cause;
  logic [RST_W-1:0] rst_cnt;
  logic             stall_hit;
  logic             in_run;

  assign in_run = (state == RUN);

  riscv_pc_stall_detector #(
    .XLEN        (XLEN),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk    (clk),
    .a_rstn (a_rstn),
    .clear  (!in_run),
    .en     (in_run),
    .pc     (pc),
    .stall  (stall_hit)
  );

  // Halt cause priority and next-state selection.
  always_comb begin
    state_nxt = state;
    cause     = NONE;
    if (mem_we && (mem_addr == TOHOST_ADDR))
      cause = TOHOST;
    else if (stall_hit)
      cause = STALL;
    else if ((TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST))
      cause = TIMEOUT;

    case (state)
      IDLE:    if (start || AUTO_START) state_nxt = RESET;
      RESET:   if (rst_cnt == RST_LAST) state_nxt = RUN;
      RUN:     if (cause != NONE) state_nxt = DONE;
      DONE:    if (start) state_nxt = RESET;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered outputs, counters and sticky result capture.
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      core_rstn   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      stalled     <= 1'b0;
      exit_code   <= '0;
      cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      core_rstn <= (state_nxt == RUN);
      busy      <= (state_nxt == RESET) || (state_nxt == RUN);

      if ((state != RESET) && (state_nxt == RESET)) begin
        rst_cnt     <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
        timeout     <= 1'b0;
        stalled     <= 1'b0;
        exit_code   <= '0;
        cycle_count <= '0;
      end else if (state == RESET) begin
        rst_cnt <= rst_cnt + 1'b1;
      end

      if (state == RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        case (cause)
          TOHOST: begin
            done      <= 1'b1;
            exit_code <= mem_wdata;
            pass      <= (mem_wdata == XLEN'(1));
          end
          STALL: begin
            done    <= 1'b1;
            stalled <= 1'b1;
          end
          TIMEOUT: begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
